// File: rtl/wb_stub_slave_pkg.sv
// Shared definitions for the Wishbone stub slave: response modes, FSM states
// and the width helper for the wait counter.
package wb_stub_slave_pkg;

    localparam int WB_STUB_MODE_ERR         = 0;
    localparam int WB_STUB_MODE_ACK         = 1;
    localparam int WB_STUB_MODE_TIMEOUT_ERR = 2;
    localparam int WB_STUB_MODE_HANG        = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_stub_slave_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_stub_slave.sv
// Wishbone classic slave standing in for an absent peripheral: answers with
// err, ack, a timed-out err or nothing, and records the last access.
module wb_stub_slave
    import wb_stub_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 24,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RESPONSE_MODE  = 0,
    parameter int                    LATENCY        = 0,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [DATA_WIDTH-1:0] READ_DATA      = '0,
    parameter int                    COUNT_WIDTH    = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rstn_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [COUNT_WIDTH-1:0]  access_count_o,
    output logic [COUNT_WIDTH-1:0]  err_count_o,
    output logic                    abort_o,
    output logic [ADDR_WIDTH-1:0]   last_adr_o,
    output logic [DATA_WIDTH-1:0]   last_dat_o,
    output logic                    last_we_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int WAIT_MAX  = (LATENCY > TIMEOUT_CYCLES) ? LATENCY : TIMEOUT_CYCLES;
    localparam int WAIT_W    = clog2(WAIT_MAX + 1);

    localparam bit IS_ACK  = (RESPONSE_MODE == WB_STUB_MODE_ACK);
    localparam bit IS_ERR  = (RESPONSE_MODE == WB_STUB_MODE_ERR) ||
                             (RESPONSE_MODE == WB_STUB_MODE_TIMEOUT_ERR);
    localparam bit IS_HANG = (RESPONSE_MODE == WB_STUB_MODE_HANG);

    // The response is sampled by the master LOAD_CNT+1 edges after acceptance.
    localparam logic [WAIT_W-1:0] LOAD_CNT =
        (RESPONSE_MODE == WB_STUB_MODE_TIMEOUT_ERR) ? WAIT_W'(TIMEOUT_CYCLES - 1)
                                                    : WAIT_W'(LATENCY);

    state_t               state, state_next;
    logic [WAIT_W-1:0]    wait_cnt, wait_cnt_next;
    logic                 accept;
    logic                 abort_next;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [DATA_WIDTH-1:0] rd_data;

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        abort_next    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    accept = 1'b1;
                    if (IS_HANG) begin
                        state_next = ST_WAIT;
                    end else if (LOAD_CNT == '0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = LOAD_CNT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_next    = ST_IDLE;
                    wait_cnt_next = '0;
                    abort_next    = 1'b1;
                end else if (!IS_HANG) begin
                    wait_cnt_next = wait_cnt - 1'b1;
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // Unconditional return; the request still on the bus is not
                // sampled until the following edge.
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            abort_o    <= 1'b0;
            sel_q      <= '0;
            last_adr_o <= '0;
            last_dat_o <= '0;
            last_we_o  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            wb_ack_o <= (state_next == ST_RESP) && IS_ACK;
            wb_err_o <= (state_next == ST_RESP) && IS_ERR;
            abort_o  <= abort_next;
            if (accept) begin
                sel_q      <= wb_sel_i;
                last_adr_o <= wb_adr_i;
                last_we_o  <= wb_we_i;
                if (wb_we_i) begin
                    last_dat_o <= wb_dat_i;
                end
            end
        end
    end

    // Read data only during an ack of a read, masked per selected byte lane.
    always_comb begin
        rd_data = '0;
        if (IS_ACK && (state == ST_RESP) && !last_we_o) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                rd_data[8*i +: 8] = sel_q[i] ? READ_DATA[8*i +: 8] : 8'h00;
            end
        end
    end

    assign wb_dat_o = rd_data;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_access_count (
        .clk   (wb_clk_i),
        .rstn  (wb_rstn_i),
        .inc   (accept),
        .count (access_count_o)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_err_count (
        .clk   (wb_clk_i),
        .rstn  (wb_rstn_i),
        .inc   ((state_next == ST_RESP) && IS_ERR),
        .count (err_count_o)
    );

endmodule

// File: doc/wb_stub_slave.md
Name: wb_stub_slave

Overview:
Parametrised Wishbone classic slave that stands in for an absent peripheral (UART, Ethernet, ...) when the DPI modules are not built. It replaces fixed tie-offs with a configurable response: error, acknowledge with a fixed read value, error after a bus timeout, or no response. It records the last access and counts accesses for bench checks. It sits in the test bench between a soc_top slave port and nothing.

Parameters:
ADDR_WIDTH, 24, width of wb_adr_i.
DATA_WIDTH, 32, data width, multiple of 8.
RESPONSE_MODE, 0, 0=ERR, 1=ACK, 2=TIMEOUT_ERR, 3=HANG.
LATENCY, 0, extra wait cycles before ack/err in modes 0/1 (0..255).
TIMEOUT_CYCLES, 64, cycles from request sample to err in mode 2 (1..65535).
READ_DATA, 32'h0000_0000, value returned on reads in mode 1.
COUNT_WIDTH, 16, width of the saturating counters.

Ports:
wb_clk_i  in  1  clock
wb_rstn_i  in  1  reset, asynchronous, active-low
wb_adr_i  in  ADDR_WIDTH  address
wb_dat_i  in  DATA_WIDTH  write data
wb_dat_o  out  DATA_WIDTH  read data
wb_sel_i  in  DATA_WIDTH/8  byte selects
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  acknowledge, registered
wb_err_o  out  1  error, registered
access_count_o  out  COUNT_WIDTH  accepted requests, saturating
err_count_o  out  COUNT_WIDTH  err responses, saturating
abort_o  out  1  one-cycle pulse when the master drops cyc before a response
last_adr_o  out  ADDR_WIDTH  address of last accepted request
last_dat_o  out  DATA_WIDTH  wb_dat_i of last accepted write
last_we_o  out  1  wb_we_i of last accepted request

Behaviour:
- Reset (wb_rstn_i low, asynchronous): state IDLE. All outputs and counters are 0. The wait counter is cleared. Assertion mid-transfer drops ack/err at once, and the transfer is lost.
- FSM states: IDLE, WAIT, RESP.
- IDLE: cyc&stb sampled high at edge E0 accepts the request. The stub captures last_adr_o and last_we_o, and captures last_dat_o only if we=1. access_count_o increments.
  - Mode 0/1 with LATENCY=0: go to RESP, so ack/err is high in the cycle after E0.
  - Mode 0/1 with LATENCY>0: go to WAIT with counter=LATENCY.
  - Mode 2: go to WAIT with counter=TIMEOUT_CYCLES-1.
  - Mode 3: go to WAIT permanently. The counter is not used.
- WAIT: the counter decrements each edge. At 0, go to RESP. Response is visible LATENCY+1 cycles after E0 in modes 0/1, and TIMEOUT_CYCLES cycles after E0 in mode 2.
- Abort: cyc=0 sampled in WAIT (any mode) causes return to IDLE with no response and a 1-cycle abort_o pulse. stb=0 with cyc=1 in WAIT is ignored.
- RESP: ack (mode 1) or err (modes 0/2) is high for exactly one cycle, then the FSM returns to IDLE unconditionally.
  - IDLE ignores stb on that return edge, so no double response occurs and each access takes at least 2 cycles.
  - err_count_o increments on entering RESP with err.
- wb_dat_o: only in mode 1 RESP with we=0, byte lane i = READ_DATA lane i if sel[i], else 0. Otherwise 0.
- ack and err are never high together.
- Counters saturate at all-ones; they do not wrap.
- A request arriving in the same cycle that cyc drops during WAIT is handled as an abort only; the next request needs a fresh IDLE sample.

Decomposition:
- Shared include wb_stub_defines.v holds the localparams WB_STUB_MODE_ERR/ACK/TIMEOUT_ERR/HANG and a clog2 function for the wait-counter width (max of LATENCY and TIMEOUT_CYCLES).
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rstn, inc; output count), instantiated twice for access_count_o and err_count_o.

Test Plan:
- Mode 1, LATENCY=0, READ_DATA=32'hDEAD_BEEF: read adr 24'h000010 with sel=4'b0101 -> ack in the cycle after the request sample, dat_o=32'h00AD_00EF, access_count_o=1, err=0 throughout.
- Mode 0, LATENCY=3: write adr 24'h000004, data 32'h1234_5678 -> err high for exactly 1 cycle, 4 cycles after the sample; last_dat_o=32'h1234_5678, last_we_o=1, err_count_o=1.
- Mode 2, TIMEOUT_CYCLES=10: read held -> err at cycle 10 after the sample. Repeat with cyc dropped at cycle 5 -> abort_o pulses once, no err, err_count_o unchanged.
- Mode 1: back-to-back reads with stb held high -> ack every second cycle, never two consecutive ack cycles; 5 accesses give access_count_o=5.
- COUNT_WIDTH=2, mode 0: 6 accesses -> access_count_o and err_count_o stay at 3.
- Mode 3: assert wb_rstn_i low mid-WAIT -> ack, err, counters and last_* go to 0 immediately (asynchronous); the next request after release is accepted normally.
